note_scanner: RTL and testbench
===============================

NOTE_SCANNER -- requirements
Module: note_scanner

Interface
REQ-001 The module SHALL have parameter NOTE_W, default 15, giving the window width in pixels.
REQ-002 The module SHALL have parameter NOTE_H, default 7, giving the window height in pixels.
REQ-003 The module SHALL have parameter BG_COLOUR, default 3'b000, giving the background colour that is not counted.
REQ-004 The module SHALL have parameter HIT_THRESH, default 53, giving the minimum non-background pixel count that reports a hit.
REQ-005 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port resetn, input, width 1: asynchronous, active-low reset.
REQ-007 The module SHALL have port start, input, width 1: scan request, sampled only in IDLE.
REQ-008 The module SHALL have port x_in, input, width 8: window top-left x, latched on accepted start.
REQ-009 The module SHALL have port y_in, input, width 7: window top-left y, latched on accepted start.
REQ-010 The module SHALL have port rd_colour, input, width 3: framebuffer read data, valid exactly one cycle after the matching rd_en.
REQ-011 The module SHALL have port rd_x, output, width 8: framebuffer read x address.
REQ-012 The module SHALL have port rd_y, output, width 7: framebuffer read y address.
REQ-013 The module SHALL have port rd_en, output, width 1: read strobe; rd_x/rd_y are valid while it is high.
REQ-014 The module SHALL have port busy, output, width 1: high from accepted start until done, inclusive.
REQ-015 The module SHALL have port done, output, width 1: single-cycle completion pulse.
REQ-016 The module SHALL have port hit, output, width 1: pixel_count >= HIT_THRESH, held until the next accepted start.
REQ-017 The module SHALL have port pixel_count, output, width 7: number of non-BG_COLOUR pixels in the last scan, range 0..105.

Function
REQ-018 The FSM SHALL have the states IDLE, SCAN, DRAIN and DONE.
REQ-019 Transitions: IDLE->SCAN on start; SCAN->DRAIN after the last read; DRAIN->DONE; DONE->IDLE, all unconditional except as stated.
REQ-020 start SHALL be ignored in SCAN, DRAIN and DONE; there is no queueing.
REQ-021 Sweep order SHALL be dx 0..NOTE_W-1 innermost and dy 0..NOTE_H-1 outermost, which matches the note writer's raster order.
REQ-022 rd_x SHALL equal x_base+dx modulo 256, and rd_y SHALL equal y_base+dy modulo 128; there is no clipping, and out-of-screen addresses are still issued.
REQ-023 rd_en SHALL be high in every SCAN cycle, giving NOTE_W*NOTE_H consecutive reads with no gaps; rd_x/rd_y SHALL be 0 when rd_en is low.
REQ-024 rd_colour SHALL be sampled in the cycle after each rd_en, including the DRAIN cycle for the final read, and counted when it is != BG_COLOUR.
REQ-025 The accumulator SHALL clear on accepted start; pixel_count and hit SHALL update only on entry to DONE.
REQ-026 Latency: with start in cycle 0, rd_en SHALL be high in cycles 1..105, DRAIN SHALL occupy cycle 106, and done SHALL be high in cycle 107 (defaults).
REQ-027 busy SHALL be high in cycles 1..107, and a new start SHALL be accepted no earlier than cycle 108.
REQ-028 x_in/y_in changes during a scan SHALL have no effect.

Reset
REQ-029 Asserting resetn low SHALL force IDLE immediately, including mid-scan; the scan is abandoned and no done is produced.
REQ-030 Reset values: rd_x=0, rd_y=0, rd_en=0, busy=0, done=0, hit=0, pixel_count=0, and dx, dy and the accumulator all 0.
REQ-031 After resetn deasserts, start SHALL be accepted on the first rising edge.

Structure
REQ-032 Shared package note_pkg SHALL hold NOTE_W, NOTE_H, BG_COLOUR, coordinate width constants, and the scanner state enum.
REQ-033 One sub-module, rect_sweep, SHALL contain the dx/dy counters with enable, clear, and last-pixel flag; it is reusable by the writer.
REQ-034 The accumulator SHALL be 7 bits and SHALL saturate at 127; saturation is unreachable at default sizes.

Verification
REQ-035 Scenario: all-background memory, start with x=20 and y=30 -> first read at (20,30), last read at (34,36), done in cycle 107, pixel_count=0, hit=0.
REQ-036 Scenario: memory pre-drawn with a 15x7 note of colour 3'b100 at (20,30), scanned at (20,30) -> pixel_count=105, hit=1.
REQ-037 Scenario: same note, scanned at (20,33) -> 4 overlapping rows give pixel_count=60, hit=1; scanned at (20,34) -> pixel_count=45, hit=0.
REQ-038 Scenario: wrap, scan at x=250 and y=125 -> rd_x sequence 250..255 then 0..8, and rd_y sequence 125..127 then 0..3.
REQ-039 Scenario: start re-pulsed in cycle 50 -> ignored and sweep unchanged; resetn low in cycle 60 -> rd_en=0 and busy=0 at once, and no done pulse.

Source files
------------

// File: rtl/note_pkg.sv
// note_pkg -- shared constants and types for the note scanner and the note
// writer that draws into the same framebuffer.
//   NOTE_W / NOTE_H : default note window size in pixels
//   BG_COLOUR       : framebuffer colour treated as empty
//   X_W / Y_W       : framebuffer coordinate widths (256 x 128 screen)
//   COLOUR_W        : framebuffer pixel width
//   COUNT_W         : width of the non-background pixel counter
//   scan_state_t    : scanner FSM states
package note_pkg;

  localparam int NOTE_W = 15;
  localparam int NOTE_H = 7;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int COUNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/rect_sweep.sv
// rect_sweep -- raster walker over a W x H rectangle, dx innermost.
// Shared between the note scanner and the note writer so both visit pixels
// in the same order.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : return to (0,0); wins over en
//   en          : advance one pixel; wraps to (0,0) after the last pixel
//   dx, dy      : current offset inside the rectangle
//   last        : high while (dx,dy) is the final pixel (W-1,H-1)
module rect_sweep #(
  parameter int W = 15,
  parameter int H = 7,
  localparam int DX_W = (W > 1) ? $clog2(W) : 1,
  localparam int DY_W = (H > 1) ? $clog2(H) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            en,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic            last
);

  logic dx_end;
  logic dy_end;

  assign dx_end = (dx == DX_W'(W - 1));
  assign dy_end = (dy == DY_W'(H - 1));
  assign last   = dx_end && dy_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx_end) begin
        dx <= '0;
        dy <= dy_end ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_scanner.sv
// note_scanner -- reads a NOTE_W x NOTE_H window of the framebuffer and
// counts pixels that differ from BG_COLOUR, reporting a hit when the count
// reaches HIT_THRESH.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start, x_in, y_in    : scan request and window top-left (taken in IDLE)
//   rd_x, rd_y, rd_en    : framebuffer read request, one pixel per cycle
//   rd_colour            : read data, one cycle after its rd_en
//   busy, done           : scan in progress / one-cycle completion pulse
//   hit, pixel_count     : result of the last completed scan
module note_scanner #(
  parameter int              NOTE_W     = note_pkg::NOTE_W,
  parameter int              NOTE_H     = note_pkg::NOTE_H,
  parameter logic [2:0]      BG_COLOUR  = note_pkg::BG_COLOUR,
  parameter int              HIT_THRESH = 53
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [note_pkg::X_W-1:0]     x_in,
  input  logic [note_pkg::Y_W-1:0]     y_in,
  input  logic [note_pkg::COLOUR_W-1:0] rd_colour,
  output logic [note_pkg::X_W-1:0]     rd_x,
  output logic [note_pkg::Y_W-1:0]     rd_y,
  output logic                         rd_en,
  output logic                         busy,
  output logic                         done,
  output logic                         hit,
  output logic [note_pkg::COUNT_W-1:0] pixel_count
);

  import note_pkg::*;

  localparam int DX_W = (NOTE_W > 1) ? $clog2(NOTE_W) : 1;
  localparam int DY_W = (NOTE_H > 1) ? $clog2(NOTE_H) : 1;

  scan_state_t        state;
  logic [X_W-1:0]     x_base;
  logic [Y_W-1:0]     y_base;
  logic [DX_W-1:0]    dx;
  logic [DY_W-1:0]    dy;
  logic               last;
  logic               accept;
  logic               sample_valid;
  logic [COUNT_W-1:0] acc;
  logic [COUNT_W-1:0] acc_next;

  assign accept = (state == IDLE) && start;

  rect_sweep #(
    .W(NOTE_W),
    .H(NOTE_H)
  ) u_sweep (
    .clk   (clk),
    .resetn(resetn),
    .clear (accept),
    .en    (state == SCAN),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

  // Read address decodes straight from the sweep position so every SCAN
  // cycle issues a read; addresses wrap naturally at the screen edges.
  always_comb begin
    rd_en = (state == SCAN);
    rd_x  = '0;
    rd_y  = '0;
    if (rd_en) begin
      rd_x = x_base + X_W'(dx);
      rd_y = y_base + Y_W'(dy);
    end
  end

  // Data from the previous cycle's read is counted here; saturates at 127.
  always_comb begin
    acc_next = acc;
    if (sample_valid && (rd_colour != BG_COLOUR) && (acc != '1))
      acc_next = acc + COUNT_W'(1);
  end

  // DRAIN absorbs the final read's data, so results are published on the
  // DRAIN->DONE edge with that last sample already included.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      x_base       <= '0;
      y_base       <= '0;
      sample_valid <= 1'b0;
      acc          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hit          <= 1'b0;
      pixel_count  <= '0;
    end else begin
      sample_valid <= (state == SCAN);
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            x_base <= x_in;
            y_base <= y_in;
            acc    <= '0;
            busy   <= 1'b1;
          end
        end
        SCAN: begin
          acc <= acc_next;
          if (last)
            state <= DRAIN;
        end
        DRAIN: begin
          acc         <= acc_next;
          pixel_count <= acc_next;
          hit         <= (int'(acc_next) >= HIT_THRESH);
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scanner.sv
// tb_note_scanner -- self-checking bench for note_scanner with a behavioural
// framebuffer. Expected read addresses and results are queued when each
// scan is requested and consumed as the scanner produces them.
module tb_note_scanner;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] rd_colour = '0;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_en;
  logic       busy;
  logic       done;
  logic       hit;
  logic [6:0] pixel_count;

  note_scanner dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .rd_colour  (rd_colour),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_en      (rd_en),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  // Framebuffer returns data one cycle after rd_en; junk colour otherwise so
  // mistimed sampling shows up as extra counted pixels.
  logic [2:0] fb [0:127][0:255];

  always @(posedge clk)
    rd_colour <= rd_en ? fb[rd_y][rd_x] : 3'b111;

  int n_vec  = 0;
  int n_miss = 0;

  logic [14:0] exp_addr_q[$];
  int          exp_count_q[$];
  bit          exp_hit_q[$];

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    bit         note_on;
    int         exp_count;
    bit         exp_hit;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every read must match the next queued address; reads beyond the queued
  // sweep are errors, and idle address lines must be zero.
  always @(negedge clk) begin
    logic [14:0] a;
    if (resetn) begin
      if (rd_en) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL rd_unexpected: got read at (%0d,%0d), expected none", rd_x, rd_y);
        end else begin
          a = exp_addr_q.pop_front();
          checkOutput("rd_addr", 32'({rd_y, rd_x}), 32'(a));
        end
      end else begin
        checkOutput("rd_idle_zero", 32'({rd_y, rd_x}), 32'd0);
      end
    end
  end

  // Called just after a falling edge. Drives start in cycle 0 and follows
  // the scan; optional start re-pulse and mid-scan reset at given cycles.
  task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y,
                               input int exp_count, input bit exp_hit,
                               input int repulse_cycle, input int reset_cycle);
    int  cyc;
    bit  aborted;
    int  c_exp;
    bit  h_exp;
    for (int dy = 0; dy < 7; dy++)
      for (int dx = 0; dx < 15; dx++)
        exp_addr_q.push_back({y + 7'(dy), x + 8'(dx)});
    exp_count_q.push_back(exp_count);
    exp_hit_q.push_back(exp_hit);

    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc     = 1;
    aborted = 1'b0;
    while (!done && cyc < 300) begin
      checkOutput("rd_en_window", 32'(rd_en), 32'(cyc <= 105));
      checkOutput("busy_scan", 32'(busy), 32'd1);
      if (cyc == repulse_cycle) begin
        start = 1'b1;
        x_in  = ~x;
        y_in  = ~y;
      end
      if (cyc == repulse_cycle + 1)
        start = 1'b0;
      if (cyc == reset_cycle) begin
        resetn = 1'b0;
        #1;
        checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end

    c_exp = exp_count_q.pop_front();
    h_exp = exp_hit_q.pop_front();

    if (aborted) begin
      exp_addr_q.delete();
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        checkOutput("reset_no_done", 32'(done), 32'd0);
        checkOutput("reset_no_rd", 32'(rd_en), 32'd0);
      end
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("after_reset_done", 32'(done), 32'd0);
      checkOutput("after_reset_busy", 32'(busy), 32'd0);
    end else begin
      checkOutput("done_cycle", 32'(cyc), 32'd107);
      checkOutput("busy_at_done", 32'(busy), 32'd1);
      checkOutput("pixel_count", 32'(pixel_count), 32'(c_exp));
      checkOutput("hit", 32'(hit), 32'(h_exp));
      checkOutput("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
      @(negedge clk);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("done_pulse", 32'(done), 32'd0);
      checkOutput("hit_held", 32'(hit), 32'(h_exp));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit drawn;
    vecs[0] = '{8'd20,  7'd30,  1'b0, 0,   1'b0};
    vecs[1] = '{8'd20,  7'd30,  1'b1, 105, 1'b1};
    vecs[2] = '{8'd20,  7'd33,  1'b1, 60,  1'b1};
    vecs[3] = '{8'd20,  7'd34,  1'b1, 45,  1'b0};
    vecs[4] = '{8'd250, 7'd125, 1'b1, 0,   1'b0};
    vecs[5] = '{8'd10,  7'd28,  1'b1, 25,  1'b0};
    vecs[6] = '{8'd30,  7'd30,  1'b1, 35,  1'b0};
    vecs[7] = '{8'd6,   7'd30,  1'b1, 7,   1'b0};

    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 256; c++)
        fb[r][c] = 3'b000;
    drawn = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_rd_addr", 32'({rd_y, rd_x}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hit", 32'(hit), 32'd0);
    checkOutput("rst_count", 32'(pixel_count), 32'd0);

    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].note_on && !drawn) begin
        for (int r = 0; r < 7; r++)
          for (int c = 0; c < 15; c++)
            fb[30 + r][20 + c] = 3'b100;
        drawn = 1'b1;
      end
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].exp_count, vecs[i].exp_hit, -1, -1);
    end

    $display("[TB] start re-pulse with moved coordinates during scan");
    applyStimulus(8'd20, 7'd30, 105, 1'b1, 50, -1);

    $display("[TB] reset during scan");
    applyStimulus(8'd20, 7'd33, 60, 1'b1, -1, 60);

    $display("[TB] start on first edge after reset release");
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(8'd20, 7'd33, 60, 1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
